// File: rtl/ahb_mbox_slave_if.sv
// AHB-lite slave-side bus bundle for the mailbox responder.
interface ahb_mbox_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [1:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADYin;
  logic        HREADYout;
  logic [31:0] HRDATA;
  logic [1:0]  HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADYin,
    input  HREADYout, HRDATA, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADYin,
    output HREADYout, HRDATA, HRESP
  );
endinterface

// File: rtl/ahb_mbox_slave.sv
// AHB-lite word mailbox responder: FIFO with DATA/STATUS/CTRL/THRESH registers and a level interrupt.
// Define MBOX_ERRRESP_EN to answer illegal accesses with a two-cycle ERROR response.
module ahb_mbox_slave #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            HCLK,
  input  logic            HRESET,
  ahb_mbox_slave_if.slave bus,
  output logic            nMBINT
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DPH   = 3'd1,
    ST_RWAIT = 3'd2,
    ST_ERR1  = 3'd3,
    ST_ERR2  = 3'd4
  } state_e;

  localparam logic [1:0]  A_DATA  = 2'b00;
  localparam logic [1:0]  A_STAT  = 2'b01;
  localparam logic [1:0]  A_CTRL  = 2'b10;
  localparam logic [1:0]  A_THR   = 2'b11;
  localparam logic [AW:0] THR_RST = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  state_e      state_q, state_d;
  logic [1:0]  addr_q, addr_d;
  logic        write_q, write_d;
  logic        push_q, push_d;
  logic        pop_q, pop_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] thresh_q, thresh_d;
  logic        irq_en_q, irq_en_d;
  logic        ovf_q, ovf_d;
  logic        udf_q, udf_d;
  logic        hreadyout_q, hreadyout_d;
  logic [1:0]  hresp_q, hresp_d;
  logic [31:0] hrdata_q, hrdata_d;
  logic        nmbint_q, nmbint_d;
  logic [31:0] mem_q [DEPTH];

  logic        dph_done;
  logic        acc;
  logic        data_wr;
  logic        data_rd;
  logic        size_bad;
  logic [AW:0] count;
  logic [AW:0] count_nxt;
  logic        full_nxt;
  logic        empty_nxt;
  state_e      tgt;
  logic        tgt_push;
  logic        tgt_pop;
  logic        set_ovf;
  logic        set_udf;
  logic [31:0] status;
  logic [31:0] rd_val;
  logic        unused_bits;

  assign unused_bits   = ^{bus.HADDR[31:4], bus.HADDR[1:0], bus.HTRANS[0], bus.HSIZE};
  assign count         = wr_ptr_q - rd_ptr_q;
  assign bus.HREADYout = hreadyout_q;
  assign bus.HRESP     = hresp_q;
  assign bus.HRDATA    = hrdata_q;
  assign nMBINT        = nmbint_q;

  // Data-phase completion, address-phase decode and next-state/output computation.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    push_d    = push_q;
    pop_d     = pop_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    thresh_d  = thresh_q;
    irq_en_d  = irq_en_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    hrdata_d  = 32'h0000_0000;
    tgt       = ST_DPH;
    tgt_push  = 1'b0;
    tgt_pop   = 1'b0;
    status    = 32'h0000_0000;
    rd_val    = 32'h0000_0000;
    dph_done  = (state_q == ST_DPH);

    // The completing data phase is folded in first so a pipelined access sees its effect.
    if (dph_done) begin
      if (push_q) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else if (pop_q) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else if (write_q) begin
        case (addr_q)
          A_CTRL: begin
            irq_en_d = bus.HWDATA[1];
            if (bus.HWDATA[0]) begin
              rd_ptr_d = wr_ptr_q;
            end else begin
              rd_ptr_d = rd_ptr_q;
            end
            if (bus.HWDATA[2]) begin
              ovf_d = 1'b0;
              udf_d = 1'b0;
            end else begin
              ovf_d = ovf_q;
              udf_d = udf_q;
            end
          end
          A_THR:   thresh_d = bus.HWDATA[AW:0];
          default: thresh_d = thresh_q;
        endcase
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    count_nxt = wr_ptr_d - rd_ptr_d;
    full_nxt  = count_nxt[AW];
    empty_nxt = (count_nxt == {(AW+1){1'b0}});

    status[0]      = empty_nxt;
    status[1]      = full_nxt;
    status[2]      = ovf_d;
    status[3]      = udf_d;
    status[AW+8:8] = count_nxt;

    case (bus.HADDR[3:2])
      A_STAT:  rd_val = status;
      A_CTRL:  rd_val = {30'h0, irq_en_d, 1'b0};
      A_THR:   rd_val = {{(31-AW){1'b0}}, thresh_d};
      default: rd_val = 32'h0000_0000;
    endcase

    acc     = bus.HSEL & bus.HREADYin & bus.HTRANS[1];
    data_wr = (bus.HADDR[3:2] == A_DATA) &  bus.HWRITE;
    data_rd = (bus.HADDR[3:2] == A_DATA) & ~bus.HWRITE;
    set_ovf = data_wr & full_nxt;
    set_udf = data_rd & empty_nxt;

`ifdef MBOX_ERRRESP_EN
    size_bad = (bus.HSIZE != 2'b10);
    if (size_bad | set_ovf | set_udf) begin
      tgt = ST_ERR1;
    end else if (data_rd) begin
      tgt     = ST_RWAIT;
      tgt_pop = 1'b1;
    end else begin
      tgt      = ST_DPH;
      tgt_push = data_wr;
    end
`else
    size_bad = 1'b0;
    if (data_rd & ~empty_nxt & ~size_bad) begin
      tgt     = ST_RWAIT;
      tgt_pop = 1'b1;
    end else begin
      tgt      = ST_DPH;
      tgt_push = data_wr & ~full_nxt;
    end
`endif

    case (state_q)
      ST_IDLE, ST_DPH, ST_ERR2: begin
        if (acc) begin
          state_d = tgt;
          addr_d  = bus.HADDR[3:2];
          write_d = bus.HWRITE;
          push_d  = tgt_push;
          pop_d   = tgt_pop;
          ovf_d   = ovf_d | set_ovf;
          udf_d   = udf_d | set_udf;
          if (~bus.HWRITE && (tgt == ST_DPH)) begin
            hrdata_d = rd_val;
          end else begin
            hrdata_d = 32'h0000_0000;
          end
        end else begin
          state_d = ST_IDLE;
          write_d = 1'b0;
          push_d  = 1'b0;
          pop_d   = 1'b0;
        end
      end
      ST_RWAIT: begin
        state_d  = ST_DPH;
        hrdata_d = mem_q[rd_ptr_q[AW-1:0]];
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase

    hreadyout_d = ~((state_d == ST_RWAIT) || (state_d == ST_ERR1));
    hresp_d     = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? 2'b01 : 2'b00;
    nmbint_d    = ~(irq_en_q & (count >= thresh_q));
  end

  // State, FIFO pointers, control registers and bus outputs.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      addr_q      <= 2'b00;
      write_q     <= 1'b0;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      wr_ptr_q    <= {(AW+1){1'b0}};
      rd_ptr_q    <= {(AW+1){1'b0}};
      thresh_q    <= THR_RST;
      irq_en_q    <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 2'b00;
      hrdata_q    <= 32'h0000_0000;
      nmbint_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      push_q      <= push_d;
      pop_q       <= pop_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      thresh_q    <= thresh_d;
      irq_en_q    <= irq_en_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      nmbint_q    <= nmbint_d;
    end
  end

  // FIFO storage; HWDATA is captured at the end of a DATA write data phase.
  always_ff @(posedge HCLK) begin
    if (~HRESET && dph_done && push_q) begin
      mem_q[wr_ptr_q[AW-1:0]] <= bus.HWDATA;
    end
  end

endmodule

// File: doc/ahb_mbox_slave.md
# ahb_mbox_slave

AHB-lite responder on the AHB slave bus, the target end of transfers issued by the host-commander master. It exposes a 32-bit word mailbox: the master pushes words into an internal FIFO, pops them back, and polls status and control registers. The block inserts wait states for FIFO reads, returns two-cycle ERROR responses on illegal accesses, and raises an active-low interrupt when the FIFO level reaches a programmable threshold.

## Interface
- DEPTH, 8: FIFO depth in words. Must be a power of 2, from 2 to 256.
- AW, log2(DEPTH): FIFO pointer width.
- HCLK  in  1  bus clock; all logic on the rising edge.
- HRESET  in  1  reset, synchronous, active-high.
- HSEL  in  1  slave select from the address decoder.
- HADDR  in  32  address; only [3:2] are decoded.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  2  transfer size; 10 = word.
- HWDATA  in  32  write data, valid in the data phase.
- HREADYin  in  1  bus-level HREADY.
- HREADYout  out  1  slave ready.
- HRDATA  out  32  read data.
- HRESP  out  2  00 OKAY, 01 ERROR.
- nMBINT  out  1  active-low interrupt.

## Operation
- **Accepted transfer:** HSEL & HREADYin & HTRANS[1] sampled on a rising edge. The block latches address[3:2], write and size for the following data phase. IDLE and BUSY transfers get a zero-wait OKAY response.
- **Register map (HADDR[3:2]):**
  - 00 DATA: write pushes HWDATA; read pops the head word.
  - 01 STATUS (read-only): [0] empty, [1] full, [2] sticky overflow, [3] sticky underflow, [AW+8:8] count. All other bits read 0.
  - 10 CTRL: [0] flush (write-1, self-clearing, reads 0), [1] irq_en, [2] clear sticky flags (write-1, reads 0).
  - 11 THRESH: [AW:0] threshold; reset value DEPTH.
  - Writes to STATUS are ignored with OKAY.
- **States:**
  - IDLE: no data phase pending.
  - DPH: zero-wait data phase.
  - RWAIT: DATA-read wait cycle.
  - ERR1 and ERR2: the two ERROR cycles.
- **Transitions:**
  - Accepted DATA read with FIFO non-empty -> RWAIT -> DPH.
  - Illegal access -> ERR1 -> ERR2.
  - Any other accepted transfer -> DPH.
  - From DPH or ERR2: go to the next accepted transfer's state, otherwise IDLE.
- **Illegal accesses (with the macro defined):** DATA write while full, DATA read while empty, HSIZE != 10 to any register. An illegal access sets the matching sticky flag where applicable and leaves the FIFO unchanged.
- **Count:** count = wr_ptr - rd_ptr using AW+1-bit pointers with natural wrap.
- **Interrupt:** nMBINT = ~(irq_en & count >= THRESH), registered.
- **Flush:** empties the FIFO on the cycle the CTRL write data phase completes. Sticky flags are unchanged by flush.

## Timing
- **Reset values:** HREADYout=1, HRESP=00, HRDATA=0, nMBINT=1. FIFO empty, irq_en=0, sticky flags 0, THRESH=DEPTH, state IDLE.
- **Write:** zero wait. HWDATA is captured at the end of the data phase, and count increments on that same edge.
- **STATUS/CTRL/THRESH read:** zero wait. HRDATA is valid in the data phase and reflects register state at the start of that phase.
- **DATA read:** one wait state.
  - RWAIT cycle: HREADYout=0.
  - DPH cycle: HREADYout=1, HRDATA = head word; the pop takes effect on the closing edge.
- **ERROR:**
  - ERR1: HREADYout=0, HRESP=01.
  - ERR2: HREADYout=1, HRESP=01.
  - The master may cancel the pending transfer during ERR1.
- **Pipelining:** back-to-back transfers are pipelined. A new address phase is sampled only while HREADYin=1.
- **Back-to-back DATA write then read:** the read sees the just-written word.
- **Reset mid-transfer:** if HRESET is high in any state, the block is in IDLE with reset values the next cycle. The in-flight transfer is not completed.
- **Interrupt latency:** nMBINT updates one cycle after count or THRESH changes.

## Configuration
- MBOX_ERRRESP_EN defined: illegal accesses produce the two-cycle ERROR response described above.
- MBOX_ERRRESP_EN undefined:
  - All responses are OKAY with zero wait, except the RWAIT cycle.
  - Write to a full FIFO is dropped and sets the overflow flag.
  - Read from an empty FIFO returns 0 and sets the underflow flag.
  - Non-word HSIZE is treated as a word access.

## Test plan
- Reset, then read STATUS -> 0x00000001 (empty); nMBINT=1; HREADYout=1.
- Write 0xA5A5_0001..0xA5A5_0008 to DATA, then read STATUS -> full=1, count=8. Pop 8 times -> data returned in order, each read showing exactly one HREADYout=0 cycle.
- With MBOX_ERRRESP_EN, write DATA while full -> HRESP=01 for 2 cycles (HREADYout 0 then 1); STATUS[2]=1. Without the macro -> OKAY, STATUS[2]=1, count stays 8.
- THRESH=3, CTRL=0x2, push 3 words -> nMBINT falls one cycle after the third write completes. Pop one word -> nMBINT rises.
- Push 2 words, write CTRL=0x1 -> STATUS next read = 0x00000001. Then pop -> underflow response per macro; STATUS[3]=1.
- Assert HRESET during an RWAIT cycle -> next cycle HREADYout=1, HRESP=00, FIFO empty, nMBINT=1.
